// File: rtl/controlador_sequencia_contador.sv
// Run/stop/step controller for the 0,1,2,3,10,13 sequence: rate divider, direction, preset load, lap count, auto-stop.
// Latency: one clock from sampled input to output; no backpressure, every input is sampled on every clock.
module controlador_sequencia_contador #(
   parameter int PERIOD   = 1,
   parameter int MAX_LAPS = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       step,
   input  logic       dir,
   input  logic       load,
   input  logic [3:0] load_value,
   output logic [3:0] y,
   output logic       running,
   output logic       done,
   output logic       wrap,
   output logic       load_err,
   output logic [7:0] laps
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   localparam logic [7:0] DIV_LAST  = 8'(PERIOD - 1);
   localparam logic [7:0] LAP_LIMIT = 8'(MAX_LAPS);
   localparam bit         AUTO_STOP = (MAX_LAPS != 0);

   state_t     state_q;
   logic [2:0] idx_q;
   logic [7:0] div_q;
   logic [7:0] laps_q;
   logic       wrap_q;
   logic       load_err_q;

   logic       load_ok;
   logic [2:0] load_idx;
   logic [2:0] adv_idx_d;
   logic       adv_lap;
   logic [7:0] laps_inc;
   logic       hit_limit;
   logic       do_adv;

   always_comb begin
      load_ok  = 1'b1;
      load_idx = 3'd0;
      case (load_value)
         4'd0:    load_idx = 3'd0;
         4'd1:    load_idx = 3'd1;
         4'd2:    load_idx = 3'd2;
         4'd3:    load_idx = 3'd3;
         4'd10:   load_idx = 3'd4;
         4'd13:   load_idx = 3'd5;
         default: load_ok  = 1'b0;
      endcase
   end

   // Out-of-range positions recover to 0 without counting as a lap.
   always_comb begin
      adv_idx_d = 3'd0;
      adv_lap   = 1'b0;
      if (idx_q > 3'd5) begin
         adv_idx_d = 3'd0;
      end else if (!dir) begin
         if (idx_q == 3'd5) begin
            adv_idx_d = 3'd0;
            adv_lap   = 1'b1;
         end else begin
            adv_idx_d = idx_q + 3'd1;
         end
      end else begin
         if (idx_q == 3'd0) begin
            adv_idx_d = 3'd5;
            adv_lap   = 1'b1;
         end else begin
            adv_idx_d = idx_q - 3'd1;
         end
      end
      laps_inc  = (laps_q == 8'hFF) ? 8'hFF : laps_q + 8'd1;
      hit_limit = AUTO_STOP && (laps_inc == LAP_LIMIT);
      // stop outranks step even in IDLE, where it otherwise does nothing.
      do_adv    = !load && !stop &&
                  ((state_q == ST_RUN && div_q == DIV_LAST) ||
                   (state_q == ST_IDLE && !start && step));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= 3'd0;
         div_q      <= 8'd0;
         laps_q     <= 8'd0;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
         if (load) begin
            if (load_ok) begin
               idx_q   <= load_idx;
               laps_q  <= 8'd0;
               div_q   <= 8'd0;
               state_q <= ST_IDLE;
            end else begin
               load_err_q <= 1'b1;
            end
         end else if (stop) begin
            if (state_q != ST_IDLE) begin
               state_q <= ST_IDLE;
               div_q   <= 8'd0;
            end
         end else if (start && state_q != ST_RUN) begin
            state_q <= ST_RUN;
            div_q   <= 8'd0;
            if (state_q == ST_DONE) begin
               laps_q <= 8'd0;
            end
         end else if (state_q == ST_RUN) begin
            div_q <= (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
         end

         if (do_adv) begin
            idx_q <= adv_idx_d;
            if (adv_lap) begin
               wrap_q <= 1'b1;
               laps_q <= laps_inc;
               if (hit_limit) begin
                  state_q <= ST_DONE;
               end
            end
         end
      end
   end

   always_comb begin
      case (idx_q)
         3'd0:    y = 4'd0;
         3'd1:    y = 4'd1;
         3'd2:    y = 4'd2;
         3'd3:    y = 4'd3;
         3'd4:    y = 4'd10;
         3'd5:    y = 4'd13;
         default: y = 4'd0;
      endcase
   end

   assign running  = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign wrap     = wrap_q;
   assign load_err = load_err_q;
   assign laps     = laps_q;

endmodule

// File: tb/tb_controlador_sequencia_contador.sv
// Two instances (PERIOD=1/MAX_LAPS=2 and PERIOD=3/MAX_LAPS=0) share stimulus; a sequence-level model
// predicts each instance and a monitor compares against the queued predictions every clock.
module tb_controlador_sequencia_contador;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       step = 1'b0;
   logic       dir = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_value = 4'd0;

   logic [3:0] y_a, y_b;
   logic       running_a, running_b, done_a, done_b, wrap_a, wrap_b, load_err_a, load_err_b;
   logic [7:0] laps_a, laps_b;

   always #5 clock = ~clock;

   controlador_sequencia_contador #(.PERIOD(1), .MAX_LAPS(2)) dut_a (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .step(step), .dir(dir),
      .load(load), .load_value(load_value), .y(y_a), .running(running_a), .done(done_a),
      .wrap(wrap_a), .load_err(load_err_a), .laps(laps_a)
   );

   controlador_sequencia_contador #(.PERIOD(3), .MAX_LAPS(0)) dut_b (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .step(step), .dir(dir),
      .load(load), .load_value(load_value), .y(y_b), .running(running_b), .done(done_b),
      .wrap(wrap_b), .load_err(load_err_b), .laps(laps_b)
   );

   typedef struct {
      int pos;
      int ticks;
      int laps;
      bit run;
      bit dn;
      bit wrap;
      bit err;
   } mdl_t;

   typedef struct {
      logic [3:0] y;
      logic       run;
      logic       dn;
      logic       wrap;
      logic       err;
      logic [7:0] laps;
   } exp_t;

   int   seq_val [6] = '{0, 1, 2, 3, 10, 13};
   mdl_t ma, mb;
   exp_t qa[$];
   exp_t qb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic mdl_t mreset();
      mdl_t r;
      r.pos = 0; r.ticks = 0; r.laps = 0;
      r.run = 1'b0; r.dn = 1'b0; r.wrap = 1'b0; r.err = 1'b0;
      return r;
   endfunction

   function automatic mdl_t mstep(mdl_t s, int period, int maxl, bit st, bit sp, bit stp,
                                  bit d, bit ld, logic [3:0] lv);
      mdl_t n;
      int   li;
      bit   adv;
      bit   lap;
      n = s; n.wrap = 1'b0; n.err = 1'b0;
      li = -1; adv = 1'b0; lap = 1'b0;
      for (int k = 0; k < 6; k++) if (int'(lv) == seq_val[k]) li = k;
      if (ld) begin
         if (li >= 0) begin
            n.pos = li; n.laps = 0; n.ticks = 0; n.run = 1'b0; n.dn = 1'b0;
         end else begin
            n.err = 1'b1;
         end
      end else if (sp) begin
         if (s.run || s.dn) begin
            n.run = 1'b0; n.dn = 1'b0; n.ticks = 0;
         end
      end else if (st && !s.run) begin
         n.run = 1'b1; n.dn = 1'b0; n.ticks = 0;
         if (s.dn) n.laps = 0;
      end else if (s.run) begin
         adv = ((s.ticks % period) == period - 1);
         n.ticks = s.ticks + 1;
      end else if (!s.dn && stp) begin
         adv = 1'b1;
      end
      if (adv) begin
         if (!d) begin
            lap = (s.pos == 5); n.pos = (s.pos + 1) % 6;
         end else begin
            lap = (s.pos == 0); n.pos = (s.pos + 5) % 6;
         end
         if (lap) begin
            n.wrap = 1'b1;
            n.laps = (s.laps < 255) ? s.laps + 1 : 255;
            if (maxl != 0 && n.laps == maxl) begin
               n.run = 1'b0; n.dn = 1'b1;
            end
         end
      end
      return n;
   endfunction

   function automatic exp_t expect_of(mdl_t m);
      exp_t e;
      e.y = 4'(seq_val[m.pos]);
      e.run = m.run; e.dn = m.dn; e.wrap = m.wrap; e.err = m.err;
      e.laps = 8'(m.laps);
      return e;
   endfunction

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle(bit rst, bit st, bit sp, bit stp, bit d, bit ld, logic [3:0] lv);
      @(negedge clock);
      reset = rst; start = st; stop = sp; step = stp; dir = d; load = ld; load_value = lv;
      if (!rst) begin
         ma = mreset(); mb = mreset();
      end else begin
         ma = mstep(ma, 1, 2, st, sp, stp, d, ld, lv);
         mb = mstep(mb, 3, 0, st, sp, stp, d, ld, lv);
      end
      qa.push_back(expect_of(ma));
      qb.push_back(expect_of(mb));
   endtask

   task automatic idle(int n, bit d);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, d, 1'b0, 4'd0);
   endtask

   // Reset asserted between clock edges must clear outputs without waiting for an edge.
   task automatic async_reset_check();
      @(posedge clock);
      #3;
      chk("pre_reset_y_a", 8'(y_a), 8'd10);
      chk("pre_reset_running_a", 8'(running_a), 8'd1);
      reset = 1'b0;
      #1;
      chk("async_y_a", 8'(y_a), 8'd0);
      chk("async_running_a", 8'(running_a), 8'd0);
      chk("async_laps_a", laps_a, 8'd0);
      chk("async_y_b", 8'(y_b), 8'd0);
      chk("async_running_b", 8'(running_b), 8'd0);
      ma = mreset(); mb = mreset();
   endtask

   initial begin
      exp_t ea, eb;
      forever begin
         @(posedge clock);
         #1;
         if (qa.size() != 0) begin
            ea = qa.pop_front();
            chk("a.y", 8'(y_a), 8'(ea.y));
            chk("a.running", 8'(running_a), 8'(ea.run));
            chk("a.done", 8'(done_a), 8'(ea.dn));
            chk("a.wrap", 8'(wrap_a), 8'(ea.wrap));
            chk("a.load_err", 8'(load_err_a), 8'(ea.err));
            chk("a.laps", laps_a, ea.laps);
         end
         if (qb.size() != 0) begin
            eb = qb.pop_front();
            chk("b.y", 8'(y_b), 8'(eb.y));
            chk("b.running", 8'(running_b), 8'(eb.run));
            chk("b.done", 8'(done_b), 8'(eb.dn));
            chk("b.wrap", 8'(wrap_b), 8'(eb.wrap));
            chk("b.load_err", 8'(load_err_b), 8'(eb.err));
            chk("b.laps", laps_b, eb.laps);
         end
      end
   end

   initial begin
      ma = mreset(); mb = mreset();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      idle(1, 1'b0);

      // Forward run from reset, one advance per clock on instance A.
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      idle(8, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

      // Backward run from 0, three clocks per value on instance B.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      idle(20, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);

      // Auto-stop after two laps on A, step ignored in DONE, restart clears laps.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      idle(14, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      idle(3, 1'b0);

      // Valid preset, rejected preset, then single steps across the lap boundary.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
      idle(1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      idle(1, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

      // load beats stop and start in the same cycle.
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      idle(3, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
      idle(2, 1'b0);

      // Reach y=10 in RUN on A, then drop reset between edges.
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      idle(1, 1'b0);
      async_reset_check();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom % 200) != 0, ($urandom % 8) == 0, ($urandom % 16) == 0,
               ($urandom % 3) == 0, 1'($urandom), ($urandom % 12) == 0, 4'($urandom));
      end

      @(negedge clock);
      @(negedge clock);
      chk("drain_a", 8'(qa.size()), 8'd0);
      chk("drain_b", 8'(qb.size()), 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
